// File: rtl/nf5_loader_pkg.sv
// Shared types and sizes for the NF5 program loader.
package nf5_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WR,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_IDX_W = $clog2(WORD_BYTES);
  localparam int unsigned WORD_W     = 8 * WORD_BYTES;

endpackage

// File: rtl/nf5_prog_loader_if.sv
// Byte-stream input and memory word-write bus of the program loader.
interface nf5_prog_loader_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  // master: host stream source plus memory; slave: the loader itself
  modport master (
    output in_valid, in_data, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/nf5_loader_word_asm.sv
// Assembles little-endian 32-bit words from a byte stream; serves both header and payload.
module nf5_loader_word_asm
  import nf5_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] word_c,
  output logic              word_done_c
);

  logic [BYTE_IDX_W-1:0] idx_q;

  // word_c is the word including the byte being accepted this cycle
  always_comb begin
    word_c                      = word;
    word_c[{idx_q, 3'b000} +: 8] = byte_in;
    word_done_c                 = byte_en & (idx_q == BYTE_IDX_W'(WORD_BYTES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      word  <= '0;
    end else if (byte_en) begin
      idx_q <= idx_q + BYTE_IDX_W'(1);
      word  <= word_c;
    end
  end

endmodule

// File: rtl/nf5_prog_loader.sv
// NF5 program loader: header/payload/checksum framing, memory word writes, core reset release.
module nf5_prog_loader
  import nf5_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  nf5_prog_loader_if.slave bus,
  output logic             core_rst_n,
  output logic             load_done,
  output logic             load_err
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned N_CMP_W = WORD_W + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        sum_q, sum_d;
  logic              in_ready_q;
  logic              mem_we_q;
  logic              accept_c;
  logic              asm_en_c;
  logic              word_done_c;
  logic [WORD_W-1:0] word_c;
  logic [WORD_W-1:0] wdata_q;

  assign accept_c = bus.in_valid & in_ready_q;
  assign asm_en_c = accept_c & ((state_q == HDR) | (state_q == DATA));

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  nf5_loader_word_asm u_word_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_en    (asm_en_c),
    .byte_in    (bus.in_data),
    .word       (wdata_q),
    .word_c     (word_c),
    .word_done_c(word_done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HDR;
    else        state_q <= state_d;
  end

  // Next state and datapath updates
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    unique case (state_q)
      HDR: begin
        if (word_done_c) begin
          if ((word_c == '0) || ({1'b0, word_c} > N_CMP_W'(DEPTH))) begin
            state_d = ERR;
          end else begin
            n_d     = CNT_W'(word_c);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept_c)    sum_d   = sum_q + bus.in_data;
        if (word_done_c) state_d = WR;
      end
      WR: begin
        if (bus.mem_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == n_q) ? CSUM : DATA;
        end
      end
      CSUM: begin
        if (accept_c) state_d = (bus.in_data == sum_q) ? DONE : ERR;
      end
      DONE, ERR: ;
      default: state_d = ERR;
    endcase
  end

  // Registered outputs follow the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= '0;
      cnt_q      <= '0;
      addr_q     <= START_ADDR;
      sum_q      <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      sum_q      <= sum_d;
      in_ready_q <= (state_d == HDR) | (state_d == DATA) | (state_d == CSUM);
      mem_we_q   <= (state_d == WR);
      core_rst_n <= (state_d == DONE);
      load_done  <= (state_d == DONE);
      load_err   <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_nf5_prog_loader.sv
// Directed bench for nf5_prog_loader with a word-memory model and configurable write backpressure.
module tb_nf5_prog_loader;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic core_rst_n, load_done, load_err;

  int n_cmp = 0;
  int n_bad = 0;

  int   stall_cfg = 0;
  int   wait_cnt  = 0;
  bit   clr_req   = 1'b0;
  bit   stream_dead = 1'b0;

  logic [31:0] mem    [DEPTH];
  int          wr_cnt [DEPTH];
  int          total_writes = 0;
  int          we_cycles    = 0;
  int          stall_viol   = 0;
  bit          hold_flag    = 1'b0;
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [31:0]       hold_data = '0;

  nf5_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  nf5_prog_loader #(
    .ADDR_W    (ADDR_W),
    .START_ADDR(ADDR_W'(0))
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .core_rst_n(core_rst_n),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  assign bus.mem_ready = (stall_cfg == 0) || (wait_cnt >= stall_cfg);

  // Memory model: records writes and any change of the request while it is stalled
  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i]    = '0;
        wr_cnt[i] = 0;
      end
      total_writes = 0;
      we_cycles    = 0;
      stall_viol   = 0;
      hold_flag    = 1'b0;
      wait_cnt    <= 0;
    end else begin
      if (hold_flag && (!bus.mem_we || bus.mem_addr != hold_addr || bus.mem_wdata != hold_data))
        stall_viol++;
      hold_flag = 1'b0;
      if (bus.mem_we) begin
        we_cycles++;
        if (bus.in_ready) stall_viol++;
        if (bus.mem_ready) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          wr_cnt[bus.mem_addr]++;
          total_writes++;
          wait_cnt <= 0;
        end else begin
          wait_cnt <= wait_cnt + 1;
          hold_flag = 1'b1;
          hold_addr = bus.mem_addr;
          hold_data = bus.mem_wdata;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    stall_cfg    = 0;
    stream_dead  = 1'b0;
    clr_req      = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    if (stream_dead) return;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_byte_timeout: in_ready=%0b required 1 (byte %02h)", bus.in_ready, b);
      bus.in_valid = 1'b0;
      stream_dead  = 1'b1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] n_hdr, input logic [31:0] w[$],
                            input logic [7:0] csum_flip, input int gap_max);
    logic [7:0]  s;
    logic [31:0] x;
    s = 8'h00;
    for (int i = 0; i < 4; i++) send_byte(n_hdr[8*i +: 8]);
    foreach (w[i]) begin
      x = w[i];
      for (int k = 0; k < 4; k++) begin
        s = s + x[8*k +: 8];
        send_byte(x[8*k +: 8]);
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
    end
    send_byte(s ^ csum_flip);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst_n        = 1'b0;
    clr_req      = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
    n_cmp++; if (bus.mem_addr !== 12'h000) begin n_bad++; $display("FAIL rst_mem_addr: got %h expected 000", bus.mem_addr); end
    n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h expected 0", bus.mem_wdata); end
    n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_core_rst_n: got %b expected 0", core_rst_n); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL rst_load_done: got %b expected 0", load_done); end
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL rst_load_err: got %b expected 0", load_err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL hdr_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_load_basic();
    logic [31:0] w[$];
    do_reset();
    w = '{32'h0000_0013, 32'h0010_0093};
    send_frame(32'd2, w, 8'h00, 0);
    n_cmp++; if (mem[0] !== 32'h0000_0013) begin n_bad++; $display("FAIL basic_addr0: got %h expected 00000013", mem[0]); end
    n_cmp++; if (mem[1] !== 32'h0010_0093) begin n_bad++; $display("FAIL basic_addr1: got %h expected 00100093", mem[1]); end
    n_cmp++; if (total_writes != 2) begin n_bad++; $display("FAIL basic_writes: got %0d expected 2", total_writes); end
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL basic_load_done: got %b expected 1", load_done); end
    n_cmp++; if (core_rst_n !== 1'b1) begin n_bad++; $display("FAIL basic_core_rst_n: got %b expected 1", core_rst_n); end
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL basic_load_err: got %b expected 0", load_err); end
  endtask

  task automatic test_bad_length();
    logic [31:0] hdrs [2];
    logic [31:0] h;
    hdrs = '{32'h0000_0000, 32'h0000_1001};
    for (int j = 0; j < 2; j++) begin
      do_reset();
      h = hdrs[j];
      for (int i = 0; i < 4; i++) send_byte(h[8*i +: 8]);
      repeat (3) @(negedge clk);
      n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL badlen_load_err n=%h: got %b expected 1", h, load_err); end
      n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL badlen_core_rst_n n=%h: got %b expected 0", h, core_rst_n); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL badlen_in_ready n=%h: got %b expected 0", h, bus.in_ready); end
      n_cmp++; if (we_cycles != 0) begin n_bad++; $display("FAIL badlen_mem_we n=%h: got %0d we cycles expected 0", h, we_cycles); end
      n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL badlen_load_done n=%h: got %b expected 0", h, load_done); end
    end
  endtask

  task automatic test_bad_csum();
    logic [31:0] w[$];
    do_reset();
    w = '{32'h0000_0013, 32'h0010_0093};
    send_frame(32'd2, w, 8'h01, 0);
    n_cmp++; if (total_writes != 2) begin n_bad++; $display("FAIL csum_writes: got %0d expected 2", total_writes); end
    n_cmp++; if (mem[1] !== 32'h0010_0093) begin n_bad++; $display("FAIL csum_addr1: got %h expected 00100093", mem[1]); end
    n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL csum_load_err: got %b expected 1", load_err); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL csum_load_done: got %b expected 0", load_done); end
    n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL csum_core_rst_n: got %b expected 0", core_rst_n); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[$];
    do_reset();
    stall_cfg = 3;
    w = '{32'h0000_0013, 32'h0010_0093};
    send_frame(32'd2, w, 8'h00, 0);
    n_cmp++; if (stall_viol != 0) begin n_bad++; $display("FAIL bp_stable: got %0d violations expected 0", stall_viol); end
    n_cmp++; if (we_cycles != 8) begin n_bad++; $display("FAIL bp_we_cycles: got %0d expected 8", we_cycles); end
    n_cmp++; if (mem[0] !== 32'h0000_0013) begin n_bad++; $display("FAIL bp_addr0: got %h expected 00000013", mem[0]); end
    n_cmp++; if (mem[1] !== 32'h0010_0093) begin n_bad++; $display("FAIL bp_addr1: got %h expected 00100093", mem[1]); end
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL bp_load_done: got %b expected 1", load_done); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] w[$];
    logic [7:0]  partial [10];
    do_reset();
    partial = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33};
    for (int i = 0; i < 10; i++) send_byte(partial[i]);
    n_cmp++; if (total_writes != 1) begin n_bad++; $display("FAIL mid_pre_writes: got %0d expected 1", total_writes); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.mem_addr !== 12'h000) begin n_bad++; $display("FAIL mid_rst_addr: got %h expected 000", bus.mem_addr); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_in_ready: got %b expected 0", bus.in_ready); end
    do_reset();
    w = '{32'h1234_5678, 32'h9ABC_DEF0};
    send_frame(32'd2, w, 8'h00, 0);
    n_cmp++; if (mem[0] !== 32'h1234_5678 || wr_cnt[0] != 1) begin n_bad++; $display("FAIL mid_addr0: got %h (x%0d) expected 12345678 (x1)", mem[0], wr_cnt[0]); end
    n_cmp++; if (mem[1] !== 32'h9ABC_DEF0) begin n_bad++; $display("FAIL mid_addr1: got %h expected 9abcdef0", mem[1]); end
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL mid_load_done: got %b expected 1", load_done); end
  endtask

  task automatic test_full_capacity();
    logic [31:0] w[$];
    int bad_words;
    int accepted;
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) w.push_back($urandom);
    send_frame(32'(DEPTH), w, 8'h00, 1);
    bad_words = 0;
    for (int i = 0; i < int'(DEPTH); i++)
      if (wr_cnt[i] != 1 || mem[i] !== w[i]) bad_words++;
    n_cmp++; if (total_writes != int'(DEPTH)) begin n_bad++; $display("FAIL full_writes: got %0d expected %0d", total_writes, DEPTH); end
    n_cmp++; if (bad_words != 0) begin n_bad++; $display("FAIL full_contents: got %0d bad words expected 0", bad_words); end
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL full_load_done: got %b expected 1", load_done); end
    accepted = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    repeat (8) begin
      @(negedge clk);
      if (bus.in_ready) accepted++;
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (accepted != 0) begin n_bad++; $display("FAIL full_trailing: got %0d accepted expected 0", accepted); end
    n_cmp++; if (total_writes != int'(DEPTH)) begin n_bad++; $display("FAIL full_trailing_writes: got %0d expected %0d", total_writes, DEPTH); end
    n_cmp++; if (load_err !== 1'b0 || core_rst_n !== 1'b1) begin n_bad++; $display("FAIL full_terminal: got err=%b core_rst_n=%b expected 0/1", load_err, core_rst_n); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_basic();
    test_bad_length();
    test_bad_csum();
    test_backpressure();
    test_reset_midframe();
    test_full_capacity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
